// File: rtl/pll_seq_pkg.sv
// pll_reset_sequencer shared types and defaults.
// State encoding and dwell constants.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    POR_WAIT,
    WAIT_LOCK,
    QUAL,
    STDY_CLR,
    REL_CORE,
    RUN,
    FAULT
  } pll_seq_state_t;

  localparam int POR_CYCLES_DEF     = 1000;
  localparam int QUAL_CYCLES_DEF    = 256;
  localparam int STAGE_CYCLES_DEF   = 16;
  localparam int TIMEOUT_CYCLES_DEF = 100000;

  // CC_PLL needs the steady-lock reset held for two cycles.
  localparam int STDY_CYCLES = 2;

  localparam int UNLOCK_W = 8;

  function automatic int max_of4(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// Single-bit 2-flop synchronizer.
// Async active-low reset clears both flops.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL lock qualification and ordered reset release.
// Runs on the PLL reference clock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int POR_CYCLES     = POR_CYCLES_DEF,
  parameter int QUAL_CYCLES    = QUAL_CYCLES_DEF,
  parameter int STAGE_CYCLES   = STAGE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clock_in,
  input  logic       rstn_in,
  input  logic       pll_lock_in,
  input  logic       pll_lock_stdy_in,
  input  logic       fault_clr_in,
  output logic       stdy_rst_out,
  output logic       core_rstn_out,
  output logic       dac_rstn_out,
  output logic       ready_out,
  output logic       fault_out,
  output logic [7:0] unlock_cnt_out
);

  localparam int CNT_MAX_I = max_of4(
    POR_CYCLES, QUAL_CYCLES, STAGE_CYCLES, TIMEOUT_CYCLES);
  localparam int CW = $clog2(CNT_MAX_I) + 1;

  localparam logic [CW-1:0] POR_LAST   = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] QUAL_LAST  = CW'(QUAL_CYCLES - 1);
  localparam logic [CW-1:0] STDY_LAST  = CW'(STDY_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = {CW{1'b1}};

  logic lock_s;
  logic stdy_s;

  pll_seq_state_t state;
  pll_seq_state_t nxt;
  logic [CW-1:0]  cnt;
  logic           loss;

  sync_2ff u_sync_lock (
    .clk   (clock_in),
    .rst_n (rstn_in),
    .d     (pll_lock_in),
    .q     (lock_s)
  );

  sync_2ff u_sync_stdy (
    .clk   (clock_in),
    .rst_n (rstn_in),
    .d     (pll_lock_stdy_in),
    .q     (stdy_s)
  );

  // Next state; lock loss wins over any dwell expiring.
  always_comb begin
    nxt  = state;
    loss = 1'b0;
    unique case (state)
      POR_WAIT: begin
        if (cnt == POR_LAST) nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) nxt = QUAL;
        else if (cnt == TO_LAST) nxt = FAULT;
      end
      QUAL: begin
        if (!lock_s) nxt = WAIT_LOCK;
        else if (cnt == QUAL_LAST) nxt = STDY_CLR;
      end
      STDY_CLR: begin
        if (!lock_s) nxt = WAIT_LOCK;
        else if (cnt == STDY_LAST) nxt = REL_CORE;
      end
      REL_CORE: begin
        if (!lock_s) begin
          nxt  = WAIT_LOCK;
          loss = 1'b1;
        end else if (cnt == STAGE_LAST) begin
          nxt = RUN;
        end
      end
      RUN: begin
        if (!lock_s || !stdy_s) begin
          nxt  = WAIT_LOCK;
          loss = 1'b1;
        end
      end
      FAULT: begin
        if (fault_clr_in) nxt = WAIT_LOCK;
      end
      default: nxt = POR_WAIT;
    endcase
  end

  // State, shared dwell counter and registered output decodes.
  always_ff @(posedge clock_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state         <= POR_WAIT;
      cnt           <= '0;
      stdy_rst_out  <= 1'b0;
      core_rstn_out <= 1'b0;
      dac_rstn_out  <= 1'b0;
      ready_out     <= 1'b0;
      fault_out     <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
      stdy_rst_out  <= (nxt == STDY_CLR);
      core_rstn_out <= (nxt == REL_CORE) || (nxt == RUN);
      dac_rstn_out  <= (nxt == RUN);
      ready_out     <= (nxt == RUN);
      fault_out     <= (nxt == FAULT);
    end
  end

  // Saturating count of lock losses after core release.
  always_ff @(posedge clock_in or negedge rstn_in) begin
    if (!rstn_in) begin
      unlock_cnt_out <= '0;
    end else if (loss && (unlock_cnt_out != 8'hFF)) begin
      unlock_cnt_out <= unlock_cnt_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer.
// Second instance uses short dwells for saturation.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       rstn;
  logic       lock;
  logic       stdy;
  logic       fclr;
  logic       stdy_rst;
  logic       core_rstn;
  logic       dac_rstn;
  logic       ready;
  logic       fault;
  logic [7:0] unlock;

  logic       rstn2;
  logic       lock2;
  logic       stdy2;
  logic       fclr2;
  logic       stdy_rst2;
  logic       core_rstn2;
  logic       dac_rstn2;
  logic       ready2;
  logic       fault2;
  logic [7:0] unlock2;

  int total;
  int bad;

  pll_reset_sequencer #(
    .POR_CYCLES     (1000),
    .QUAL_CYCLES    (256),
    .STAGE_CYCLES   (16),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .clock_in         (clk),
    .rstn_in          (rstn),
    .pll_lock_in      (lock),
    .pll_lock_stdy_in (stdy),
    .fault_clr_in     (fclr),
    .stdy_rst_out     (stdy_rst),
    .core_rstn_out    (core_rstn),
    .dac_rstn_out     (dac_rstn),
    .ready_out        (ready),
    .fault_out        (fault),
    .unlock_cnt_out   (unlock)
  );

  pll_reset_sequencer #(
    .POR_CYCLES     (8),
    .QUAL_CYCLES    (4),
    .STAGE_CYCLES   (2),
    .TIMEOUT_CYCLES (1000)
  ) dut2 (
    .clock_in         (clk),
    .rstn_in          (rstn2),
    .pll_lock_in      (lock2),
    .pll_lock_stdy_in (stdy2),
    .fault_clr_in     (fclr2),
    .stdy_rst_out     (stdy_rst2),
    .core_rstn_out    (core_rstn2),
    .dac_rstn_out     (dac_rstn2),
    .ready_out        (ready2),
    .fault_out        (fault2),
    .unlock_cnt_out   (unlock2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    lock = 1'b0;
    stdy = 1'b0;
    fclr = 1'b0;
    repeat (3) tick();
    total++;
    if (stdy_rst !== 1'b0) begin
      bad++; $display("FAIL rst_stdy got=%b exp=0", stdy_rst);
    end
    total++;
    if (core_rstn !== 1'b0) begin
      bad++; $display("FAIL rst_core got=%b exp=0", core_rstn);
    end
    total++;
    if (dac_rstn !== 1'b0) begin
      bad++; $display("FAIL rst_dac got=%b exp=0", dac_rstn);
    end
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL rst_ready got=%b exp=0", ready);
    end
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL rst_fault got=%b exp=0", fault);
    end
    total++;
    if (unlock !== 8'd0) begin
      bad++; $display("FAIL rst_unlock got=%0d exp=0", unlock);
    end
  endtask

  task automatic test_bringup();
    int core_at;
    int ready_at;
    int dac_at;
    int stdy_at;
    int stdy_n;
    bit early;
    core_at = 0; ready_at = 0; dac_at = 0;
    stdy_at = 0; stdy_n = 0; early = 1'b0;
    rstn = 1'b1;
    for (int e = 1; e <= 1400; e++) begin
      tick();
      if (e == 50) begin
        lock = 1'b1;
        stdy = 1'b1;
      end
      if (e < 1000 && (core_rstn || dac_rstn || ready ||
                       stdy_rst || fault)) early = 1'b1;
      if (stdy_rst === 1'b1) begin
        stdy_n++;
        if (stdy_at == 0) stdy_at = e;
      end
      if (core_rstn === 1'b1 && core_at == 0) core_at = e;
      if (dac_rstn === 1'b1 && dac_at == 0) dac_at = e;
      if (ready === 1'b1 && ready_at == 0) ready_at = e;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL bu_por_early got=%b exp=0", early);
    end
    total++;
    if (stdy_at != 1257) begin
      bad++; $display("FAIL bu_stdy_at got=%0d exp=1257", stdy_at);
    end
    total++;
    if (stdy_n != 2) begin
      bad++; $display("FAIL bu_stdy_len got=%0d exp=2", stdy_n);
    end
    total++;
    if (core_at != 1259) begin
      bad++; $display("FAIL bu_core_at got=%0d exp=1259", core_at);
    end
    total++;
    if (dac_at != 1275) begin
      bad++; $display("FAIL bu_dac_at got=%0d exp=1275", dac_at);
    end
    total++;
    if (ready_at != 1275) begin
      bad++; $display("FAIL bu_ready_at got=%0d exp=1275", ready_at);
    end
  endtask

  task automatic test_stdy_loss();
    int n;
    int sp;
    stdy = 1'b0;
    tick();
    tick();
    total++;
    if (core_rstn !== 1'b1) begin
      bad++; $display("FAIL sl_hold got=%b exp=1", core_rstn);
    end
    tick();
    total++;
    if ({core_rstn, dac_rstn, ready} !== 3'b000) begin
      bad++;
      $display("FAIL sl_resets got=%b exp=000",
               {core_rstn, dac_rstn, ready});
    end
    total++;
    if (unlock !== 8'd1) begin
      bad++; $display("FAIL sl_unlock got=%0d exp=1", unlock);
    end
    stdy = 1'b1;
    n = 0;
    sp = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (stdy_rst === 1'b1) sp++;
    end
    total++;
    if (n != 275) begin
      bad++; $display("FAIL sl_requal got=%0d exp=275", n);
    end
    total++;
    if (sp != 2) begin
      bad++; $display("FAIL sl_stdy_len got=%0d exp=2", sp);
    end
  endtask

  task automatic test_async_reset();
    int n;
    lock = 1'b0;
    tick();
    lock = 1'b1;
    n = 0;
    while (core_rstn !== 1'b0 && n < 10) begin
      tick(); n++;
    end
    n = 0;
    while (core_rstn !== 1'b1 && n < 400) begin
      tick(); n++;
    end
    repeat (5) tick();
    total++;
    if ({core_rstn, dac_rstn} !== 2'b10) begin
      bad++;
      $display("FAIL ar_in_rel got=%b exp=10", {core_rstn, dac_rstn});
    end
    total++;
    if (unlock !== 8'd2) begin
      bad++; $display("FAIL ar_unlock_pre got=%0d exp=2", unlock);
    end
    #2;
    rstn = 1'b0;
    #1;
    total++;
    if ({stdy_rst, core_rstn, dac_rstn, ready, fault} !== 5'b0) begin
      bad++;
      $display("FAIL ar_async got=%b exp=00000",
               {stdy_rst, core_rstn, dac_rstn, ready, fault});
    end
    total++;
    if (unlock !== 8'd0) begin
      bad++; $display("FAIL ar_unlock got=%0d exp=0", unlock);
    end
  endtask

  task automatic test_qual_glitch();
    int core_at;
    int ready_at;
    int stdy_at;
    int stdy_n;
    bit early;
    core_at = 0; ready_at = 0; stdy_at = 0;
    stdy_n = 0; early = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    for (int e = 1; e <= 1500; e++) begin
      tick();
      if (e == 1199) lock = 1'b0;
      if (e == 1200) lock = 1'b1;
      if (e < 1000 && (core_rstn || ready || stdy_rst)) early = 1'b1;
      if (stdy_rst === 1'b1) begin
        stdy_n++;
        if (stdy_at == 0) stdy_at = e;
      end
      if (core_rstn === 1'b1 && core_at == 0) core_at = e;
      if (ready === 1'b1 && ready_at == 0) ready_at = e;
    end
    total++;
    if (early !== 1'b0) begin
      bad++; $display("FAIL qg_por_early got=%b exp=0", early);
    end
    total++;
    if (stdy_at != 1459) begin
      bad++; $display("FAIL qg_stdy_at got=%0d exp=1459", stdy_at);
    end
    total++;
    if (stdy_n != 2) begin
      bad++; $display("FAIL qg_stdy_len got=%0d exp=2", stdy_n);
    end
    total++;
    if (core_at != 1461) begin
      bad++; $display("FAIL qg_core_at got=%0d exp=1461", core_at);
    end
    total++;
    if (ready_at != 1477) begin
      bad++; $display("FAIL qg_ready_at got=%0d exp=1477", ready_at);
    end
    total++;
    if (unlock !== 8'd0) begin
      bad++; $display("FAIL qg_unlock got=%0d exp=0", unlock);
    end
  endtask

  task automatic test_timeout();
    int n;
    lock = 1'b0;
    repeat (1002) tick();
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL to_early got=%b exp=0", fault);
    end
    tick();
    total++;
    if (fault !== 1'b1) begin
      bad++; $display("FAIL to_enter got=%b exp=1", fault);
    end
    total++;
    if ({core_rstn, dac_rstn} !== 2'b00) begin
      bad++;
      $display("FAIL to_resets got=%b exp=00", {core_rstn, dac_rstn});
    end
    total++;
    if (unlock !== 8'd1) begin
      bad++; $display("FAIL to_unlock got=%0d exp=1", unlock);
    end
    lock = 1'b1;
    repeat (20) tick();
    total++;
    if ({fault, core_rstn} !== 2'b10) begin
      bad++;
      $display("FAIL to_sticky got=%b exp=10", {fault, core_rstn});
    end
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    total++;
    if (fault !== 1'b0) begin
      bad++; $display("FAIL to_clear got=%b exp=0", fault);
    end
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      tick(); n++;
    end
    total++;
    if (n != 275) begin
      bad++; $display("FAIL to_requal got=%0d exp=275", n);
    end
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    tick();
    total++;
    if ({ready, fault} !== 2'b10) begin
      bad++;
      $display("FAIL to_clr_ignored got=%b exp=10", {ready, fault});
    end
  endtask

  task automatic test_saturate();
    int n;
    int want;
    rstn2 = 1'b1;
    n = 0;
    while (ready2 !== 1'b1 && n < 100) begin
      tick(); n++;
    end
    total++;
    if (ready2 !== 1'b1) begin
      bad++; $display("FAIL sat_start got=%b exp=1", ready2);
    end
    for (int i = 0; i < 300; i++) begin
      lock2 = 1'b0;
      n = 0;
      while (ready2 !== 1'b0 && n < 10) begin
        tick(); n++;
      end
      lock2 = 1'b1;
      want = (i + 1 > 255) ? 255 : i + 1;
      total++;
      if (unlock2 !== want[7:0]) begin
        bad++;
        $display("FAIL sat_cnt_%0d got=%0d exp=%0d", i, unlock2, want);
      end
      n = 0;
      while (ready2 !== 1'b1 && n < 50) begin
        tick(); n++;
      end
      if (ready2 !== 1'b1) begin
        total++;
        bad++;
        $display("FAIL sat_requal_%0d got=%b exp=1", i, ready2);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn2 = 1'b0;
    lock2 = 1'b1;
    stdy2 = 1'b1;
    fclr2 = 1'b0;
    test_reset();
    test_bringup();
    test_stdy_loss();
    test_async_reset();
    test_qual_glitch();
    test_timeout();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
